pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 37 +++
 rtl/pipe_perf_cnt.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU package: opcode/funct constants, register-0 id,
// and the hazard controller FSM encoding and load-use helper.
package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_MD_DONE = 2'd2
  } hz_state_e;

  // Load in EX writes a register that ID reads; r0 never counts.
  function automatic logic load_use(
    input logic       ex_memread,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) ||
            (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counter: increments on en_i, sticks at
// all-ones. Ports: clk_i, rst_i (async, low), en_i, cnt_o.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and
// multicycle mult/div stall. Inputs: ID/EX hazard fields; outputs:
// PC/IF-ID/ID-EX controls, md start/wb, stall and flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_md_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             ex_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             md_start_o,
  output logic             md_wb_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

  hz_state_e  state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;

  logic lu;
  logic run_br, run_lu, run_md;
  logic stall_en, flush_en;

  assign lu = load_use(ex_memread_i, ex_rt_i, id_rs_i,
                       id_rt_i, id_uses_rt_i);

  // Priority in RUN: branch > load-use > mult/div.
  assign run_br = (state_q == ST_RUN) && ex_branch_taken_i;
  assign run_lu = (state_q == ST_RUN) && !ex_branch_taken_i
                  && lu;
  assign run_md = (state_q == ST_RUN) && !ex_branch_taken_i
                  && !lu && id_md_i;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (run_md) begin
          state_d  = ST_MD_WAIT;
          md_cnt_d = MD_LOAD;
        end
      end
      ST_MD_WAIT: begin
        md_cnt_d = md_cnt_q - 8'd1;
        if (md_cnt_q == 8'd1) state_d = ST_MD_DONE;
      end
      ST_MD_DONE: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    md_start_o    = 1'b0;
    md_wb_o       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (run_br) begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (run_lu) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
        end else if (run_md) begin
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_bubble_o = 1'b1;
          md_start_o    = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        idex_bubble_o = 1'b1;
      end
      ST_MD_DONE: md_wb_o = 1'b1;
      default: ;
    endcase
    // Hold the pipe empty and frozen while reset is asserted.
    if (!rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
      md_start_o    = 1'b0;
      md_wb_o       = 1'b0;
    end
  end

  assign stall_en = run_lu || run_md || (state_q == ST_MD_WAIT);
  assign flush_en = run_br;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_en),
    .cnt_o (stall_cnt_o)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_en),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch, mult/div,
// mid-operation reset and counter saturation.
module tb_pipe_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
  logic        id_uses_rt_i, id_md_i, ex_memread_i;
  logic        ex_branch_taken_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o;
  logic        idex_bubble_o, md_start_o, md_wb_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  int n_chk  = 0;
  int n_pass = 0;
  int starts;
  int wbs;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(.MD_CYCLES(8), .CNT_W(16)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_rs_i           (id_rs_i),
    .id_rt_i           (id_rt_i),
    .id_uses_rt_i      (id_uses_rt_i),
    .id_md_i           (id_md_i),
    .ex_memread_i      (ex_memread_i),
    .ex_rt_i           (ex_rt_i),
    .ex_branch_taken_i (ex_branch_taken_i),
    .pc_write_o        (pc_write_o),
    .ifid_write_o      (ifid_write_o),
    .ifid_flush_o      (ifid_flush_o),
    .idex_bubble_o     (idex_bubble_o),
    .md_start_o        (md_start_o),
    .md_wb_o           (md_wb_o),
    .stall_cnt_o       (stall_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs_i = 0; id_rt_i = 0; ex_rt_i = 0;
    id_uses_rt_i = 0; id_md_i = 0; ex_memread_i = 0;
    ex_branch_taken_i = 0;
  endtask

  // ctl = {pc_write, ifid_write, flush, bubble, md_start, md_wb}
  function automatic logic [5:0] ctl();
    return {pc_write_o, ifid_write_o, ifid_flush_o,
            idex_bubble_o, md_start_o, md_wb_o};
  endfunction

  task automatic do_reset();
    idle();
    rst_i = 1'b0;
    step();
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    #12;
    chk("rst_ctl", ctl(), 6'b001100);
    chk("rst_stall", stall_cnt_o, 0);
    chk("rst_flush", flush_cnt_o, 0);
    step();
    rst_i = 1'b1;
    #1;
    chk("post_rst_ctl", ctl(), 6'b110000);
    step();
    chk("post_rst_cnt", stall_cnt_o, 0);

    // load-use on rs
    ex_memread_i = 1; ex_rt_i = 8; id_rs_i = 8;
    #1;
    chk("lu_ctl", ctl(), 6'b000100);
    step();
    idle();
    #1;
    chk("lu_after_ctl", ctl(), 6'b110000);
    chk("lu_stall", stall_cnt_o, 1);

    // load to r0 never stalls
    ex_memread_i = 1; ex_rt_i = 0; id_rs_i = 0;
    #1;
    chk("r0_ctl", ctl(), 6'b110000);
    step();
    chk("r0_stall", stall_cnt_o, 1);

    // rt match only counts when rt is a source
    ex_memread_i = 1; ex_rt_i = 5; id_rs_i = 3; id_rt_i = 5;
    id_uses_rt_i = 0;
    #1;
    chk("rt_unused_ctl", ctl(), 6'b110000);
    id_uses_rt_i = 1;
    #1;
    chk("rt_used_ctl", ctl(), 6'b000100);
    step();
    idle();
    chk("rt_stall", stall_cnt_o, 2);

    // branch beats load-use and mult/div
    do_reset();
    ex_branch_taken_i = 1; ex_memread_i = 1;
    ex_rt_i = 8; id_rs_i = 8; id_md_i = 1;
    #1;
    chk("br_ctl", ctl(), 6'b111100);
    step();
    idle();
    chk("br_flush", flush_cnt_o, 1);
    chk("br_stall", stall_cnt_o, 0);

    // mult/div, MD_CYCLES=8; branch held high is ignored while busy
    do_reset();
    starts = 0;
    id_md_i = 1;
    #1;
    chk("md_start_ctl", ctl(), 6'b000110);
    starts += int'(md_start_o);
    step();
    id_md_i = 0;
    ex_branch_taken_i = 1;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("md_wait%0d", i), ctl(), 6'b000100);
      starts += int'(md_start_o);
      step();
    end
    chk("md_done_ctl", ctl(), 6'b110001);
    chk("md_stall", stall_cnt_o, 8);
    chk("md_flush", flush_cnt_o, 0);
    chk("md_starts", starts, 1);
    step();
    chk("md_back_run", ctl(), 6'b111100);
    idle();

    // reset during 4th MD_WAIT cycle aborts
    do_reset();
    id_md_i = 1;
    step();
    idle();
    step();
    step();
    step();
    chk("abort_pre_ctl", ctl(), 6'b000100);
    rst_i = 1'b0;
    #1;
    chk("abort_ctl", ctl(), 6'b001100);
    chk("abort_stall", stall_cnt_o, 0);
    step();
    rst_i = 1'b1;
    #1;
    chk("abort_run_ctl", ctl(), 6'b110000);
    wbs = 0;
    for (int i = 0; i < 12; i++) begin
      wbs += int'(md_wb_o);
      step();
    end
    chk("abort_no_wb", wbs, 0);
    chk("abort_stall2", stall_cnt_o, 0);

    // saturation of the stall counter
    do_reset();
    ex_memread_i = 1; ex_rt_i = 9; id_rs_i = 9;
    for (int i = 0; i < 65535; i++) @(posedge clk_i);
    #1;
    chk("sat_reach", stall_cnt_o, 16'hffff);
    for (int i = 0; i < 4465; i++) @(posedge clk_i);
    #1;
    chk("sat_hold", stall_cnt_o, 16'hffff);
    chk("sat_flush", flush_cnt_o, 0);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
